// File: rtl/ay_psg_regfile.sv
// ay_psg_regfile: PSG register file behind the BK parallel-port AY decoder.
// Synchronises the one-hot command strobes and the data byte. Filters out
// short glitches and runs a small IDLE/HOLD/READ state machine. Holds
// registers R0..R15 for the synthesiser and drives read-back data.
// Optional build macro: AY_REGMASK_EN limits each register to the bit width
// the AY-3-8910 actually implements. Unused bits then store and read 0.
//
// Command protocol: the decoder presents exactly one of inact/laddr/wrpsg/
// rdpsg at a time. A command takes effect once, after it has been stable for
// CMD_STABLE synchronised cycles. Any LADDR/WRPSG/RDPSG must be separated
// from the next one by INACT.
module ay_psg_regfile #(
    parameter int         CMD_STABLE = 2,
    parameter logic [3:0] CHIP_ADDR  = 4'h0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ay_inact,
    input  logic         ay_laddr,
    input  logic         ay_wrpsg,
    input  logic         ay_rdpsg,
    input  logic [7:0]   da_in,
    output logic [7:0]   da_out,
    output logic         da_oe,
    output logic [3:0]   cur_addr,
    output logic         selected,
    output logic [127:0] regs_flat,
    output logic         env_restart
);

    typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_READ} state_t;
    typedef enum logic [1:0] {CMD_INACT, CMD_LADDR, CMD_WRPSG, CMD_RDPSG} cmd_t;

    localparam logic [3:0] STABLE = 4'(CMD_STABLE);

    logic [11:0] sync1;
    logic [11:0] sync2;
    logic [3:0]  s;
    logic [7:0]  da_s;
    cmd_t        cmd;
    logic [3:0]  s_prev;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic        s_changed;
    logic        accept;
    logic [7:0]  wr_mask;
    state_t      state;
    logic [7:0]  regs [16];

    // Two-flop synchroniser for the command strobes and the data byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {ay_inact, ay_laddr, ay_wrpsg, ay_rdpsg, da_in};
            sync2 <= sync1;
        end
    end

    assign s    = sync2[11:8];
    assign da_s = sync2[7:0];

    // Classify the synchronised vector. Zero, multi-hot and explicit inact all count as INACT.
    always_comb begin
        cmd = CMD_INACT;
        case (s)
            4'b0100: cmd = CMD_LADDR;
            4'b0010: cmd = CMD_WRPSG;
            4'b0001: cmd = CMD_RDPSG;
            default: cmd = CMD_INACT;
        endcase
    end

    // Glitch filter. Accept fires on the single cycle the run length reaches CMD_STABLE.
    always_comb begin
        s_changed = (s != s_prev);
        if (s_changed)
            cnt_next = 4'd1;
        else if (cnt >= STABLE)
            cnt_next = STABLE;
        else
            cnt_next = cnt + 4'd1;
        accept = (cnt_next == STABLE) && (s_changed || (cnt != STABLE));
    end

    // Stability counter and the previous command vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev <= '0;
            cnt    <= '0;
        end else begin
            s_prev <= s;
            cnt    <= cnt_next;
        end
    end

    // Per-register write mask. It is all ones unless the AY width limits are enabled.
    always_comb begin
        wr_mask = 8'hFF;
`ifdef AY_REGMASK_EN
        case (cur_addr)
            4'd1, 4'd3, 4'd5, 4'd13: wr_mask = 8'h0F;
            4'd6, 4'd8, 4'd9, 4'd10: wr_mask = 8'h1F;
            default:                 wr_mask = 8'hFF;
        endcase
`endif
    end

    // Command FSM. It also updates the address latch, chip select, register array and envelope pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            cur_addr    <= '0;
            selected    <= 1'b0;
            env_restart <= 1'b0;
            for (int i = 0; i < 16; i++) regs[i] <= '0;
        end else begin
            env_restart <= 1'b0;
            if (cmd == CMD_INACT) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            case (cmd)
                                CMD_LADDR: begin
                                    cur_addr <= da_s[3:0];
                                    selected <= (da_s[7:4] == CHIP_ADDR);
                                    state    <= ST_HOLD;
                                end
                                CMD_WRPSG: begin
                                    if (selected) begin
                                        regs[cur_addr] <= da_s & wr_mask;
                                        env_restart    <= (cur_addr == 4'd13);
                                    end
                                    state <= ST_HOLD;
                                end
                                CMD_RDPSG: state <= selected ? ST_READ : ST_HOLD;
                                default:   state <= ST_IDLE;
                            endcase
                        end
                    end
                    ST_HOLD: state <= ST_HOLD;
                    ST_READ: if (cmd != CMD_RDPSG) state <= ST_IDLE;
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign da_oe  = (state == ST_READ);
    assign da_out = (state == ST_READ) ? regs[cur_addr] : 8'h00;

    for (genvar g = 0; g < 16; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs[g];
    end

endmodule

// File: tb/tb_ay_psg_regfile.sv
// Directed bench for ay_psg_regfile with CMD_STABLE = 2 and CHIP_ADDR = 0.
module tb_ay_psg_regfile;

    localparam logic [3:0] C_INACT = 4'b1000;
    localparam logic [3:0] C_LADDR = 4'b0100;
    localparam logic [3:0] C_WRPSG = 4'b0010;
    localparam logic [3:0] C_RDPSG = 4'b0001;
`ifdef AY_REGMASK_EN
    localparam logic [7:0] R1_EXP = 8'h0F;
`else
    localparam logic [7:0] R1_EXP = 8'hFF;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ay_inact, ay_laddr, ay_wrpsg, ay_rdpsg;
    logic [7:0]   da_in;
    logic [7:0]   da_out;
    logic         da_oe;
    logic [3:0]   cur_addr;
    logic         selected;
    logic [127:0] regs_flat;
    logic         env_restart;

    int           check_cnt = 0;
    int           pass_cnt  = 0;
    logic [7:0]   model [16];
    logic [7:0]   exp_q [$];

    ay_psg_regfile #(.CMD_STABLE(2), .CHIP_ADDR(4'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .ay_inact(ay_inact), .ay_laddr(ay_laddr), .ay_wrpsg(ay_wrpsg), .ay_rdpsg(ay_rdpsg),
        .da_in(da_in), .da_out(da_out), .da_oe(da_oe), .cur_addr(cur_addr),
        .selected(selected), .regs_flat(regs_flat), .env_restart(env_restart)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [127:0] model_flat();
        logic [127:0] f;
        for (int i = 0; i < 16; i++) f[8*i +: 8] = model[i];
        return f;
    endfunction

    // Driver tasks: inputs change on the falling edge, so each one is sampled by the next rising edge.
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_cmd(input logic [3:0] c, input logic [7:0] d);
        {ay_inact, ay_laddr, ay_wrpsg, ay_rdpsg} = c;
        da_in = d;
    endtask

    task automatic cmd_then_inact(input logic [3:0] c, input logic [7:0] d, input int hold);
        set_cmd(c, d);
        tick(hold);
        set_cmd(C_INACT, d);
        tick(4);
    endtask

    task automatic test_reset;
        check_cnt++; if (regs_flat !== 128'h0) $display("FAIL reset_regs got=%h exp=0", regs_flat); else pass_cnt++;
        check_cnt++; if (da_out !== 8'h00) $display("FAIL reset_da_out got=%h exp=00", da_out); else pass_cnt++;
        check_cnt++; if (da_oe !== 1'b0) $display("FAIL reset_da_oe got=%b exp=0", da_oe); else pass_cnt++;
        check_cnt++; if (cur_addr !== 4'h0) $display("FAIL reset_cur_addr got=%h exp=0", cur_addr); else pass_cnt++;
        check_cnt++; if (selected !== 1'b0) $display("FAIL reset_selected got=%b exp=0", selected); else pass_cnt++;
        check_cnt++; if (env_restart !== 1'b0) $display("FAIL reset_env got=%b exp=0", env_restart); else pass_cnt++;
    endtask

    task automatic test_write_latency;
        cmd_then_inact(C_LADDR, 8'h07, 6);
        check_cnt++; if (cur_addr !== 4'h7) $display("FAIL latch_addr got=%h exp=7", cur_addr); else pass_cnt++;
        check_cnt++; if (selected !== 1'b1) $display("FAIL latch_sel got=%b exp=1", selected); else pass_cnt++;
        set_cmd(C_WRPSG, 8'h38);
        tick(3);
        check_cnt++; if (regs_flat[63:56] !== 8'h00) $display("FAIL wr_early got=%h exp=00", regs_flat[63:56]); else pass_cnt++;
        tick(1);
        model[7] = 8'h38;
        check_cnt++; if (regs_flat[63:56] !== 8'h38) $display("FAIL wr_edge4 got=%h exp=38", regs_flat[63:56]); else pass_cnt++;
        set_cmd(C_INACT, 8'h38);
        tick(4);
        check_cnt++; if (regs_flat !== model_flat()) $display("FAIL wr_flat got=%h exp=%h", regs_flat, model_flat()); else pass_cnt++;
    endtask

    task automatic test_read_masked;
        cmd_then_inact(C_LADDR, 8'h01, 6);
        cmd_then_inact(C_WRPSG, 8'hFF, 6);
        model[1] = R1_EXP;
        check_cnt++; if (regs_flat !== model_flat()) $display("FAIL r1_flat got=%h exp=%h", regs_flat, model_flat()); else pass_cnt++;
        set_cmd(C_RDPSG, 8'hFF);
        tick(3);
        check_cnt++; if (da_oe !== 1'b0) $display("FAIL oe_early got=%b exp=0", da_oe); else pass_cnt++;
        tick(1);
        exp_q.push_back(R1_EXP);
        check_cnt++; if (da_oe !== 1'b1) $display("FAIL oe_rise got=%b exp=1", da_oe); else pass_cnt++;
        check_cnt++; if (da_out !== exp_q[0]) $display("FAIL rd_data got=%h exp=%h", da_out, exp_q[0]); else pass_cnt++;
        void'(exp_q.pop_front());
        tick(3);
        set_cmd(C_INACT, 8'hFF);
        tick(2);
        check_cnt++; if (da_oe !== 1'b1) $display("FAIL oe_hold got=%b exp=1", da_oe); else pass_cnt++;
        tick(1);
        check_cnt++; if (da_oe !== 1'b0) $display("FAIL oe_fall got=%b exp=0", da_oe); else pass_cnt++;
        check_cnt++; if (da_out !== 8'h00) $display("FAIL out_idle got=%h exp=00", da_out); else pass_cnt++;
        tick(2);
    endtask

    task automatic test_env_restart;
        int pulses;
        cmd_then_inact(C_LADDR, 8'h0D, 6);
        set_cmd(C_WRPSG, 8'h0A);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (env_restart === 1'b1) begin
                pulses++;
                check_cnt++; if (regs_flat[111:104] !== 8'h0A) $display("FAIL env_coincide got=%h exp=0A", regs_flat[111:104]); else pass_cnt++;
            end
        end
        set_cmd(C_INACT, 8'h0A);
        tick(4);
        model[13] = 8'h0A;
        check_cnt++; if (pulses !== 1) $display("FAIL env_pulses got=%0d exp=1", pulses); else pass_cnt++;
        cmd_then_inact(C_LADDR, 8'h0C, 6);
        set_cmd(C_WRPSG, 8'h33);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (env_restart === 1'b1) pulses++;
        end
        set_cmd(C_INACT, 8'h33);
        tick(4);
        model[12] = 8'h33;
        check_cnt++; if (pulses !== 0) $display("FAIL env_r12 got=%0d exp=0", pulses); else pass_cnt++;
        check_cnt++; if (regs_flat !== model_flat()) $display("FAIL env_flat got=%h exp=%h", regs_flat, model_flat()); else pass_cnt++;
    endtask

    task automatic test_chip_mismatch;
        logic oe_seen;
        cmd_then_inact(C_LADDR, 8'h15, 6);
        check_cnt++; if (selected !== 1'b0) $display("FAIL mis_sel got=%b exp=0", selected); else pass_cnt++;
        check_cnt++; if (cur_addr !== 4'h5) $display("FAIL mis_addr got=%h exp=5", cur_addr); else pass_cnt++;
        cmd_then_inact(C_WRPSG, 8'h55, 6);
        check_cnt++; if (regs_flat !== model_flat()) $display("FAIL mis_write got=%h exp=%h", regs_flat, model_flat()); else pass_cnt++;
        set_cmd(C_RDPSG, 8'h00);
        oe_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            if (da_oe === 1'b1) oe_seen = 1'b1;
        end
        set_cmd(C_INACT, 8'h00);
        tick(4);
        check_cnt++; if (oe_seen !== 1'b0) $display("FAIL mis_read got=%b exp=0", oe_seen); else pass_cnt++;
    endtask

    task automatic test_glitch;
        cmd_then_inact(C_LADDR, 8'h02, 6);
        check_cnt++; if (selected !== 1'b1) $display("FAIL gl_sel got=%b exp=1", selected); else pass_cnt++;
        set_cmd(C_WRPSG, 8'hAA);
        tick(1);
        set_cmd(C_INACT, 8'hAA);
        tick(6);
        check_cnt++; if (regs_flat !== model_flat()) $display("FAIL gl_pulse got=%h exp=%h", regs_flat, model_flat()); else pass_cnt++;
        set_cmd(4'b0110, 8'h03);
        tick(8);
        set_cmd(C_INACT, 8'h03);
        tick(4);
        check_cnt++; if (regs_flat !== model_flat()) $display("FAIL gl_multi got=%h exp=%h", regs_flat, model_flat()); else pass_cnt++;
        check_cnt++; if (cur_addr !== 4'h2) $display("FAIL gl_addr got=%h exp=2", cur_addr); else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        set_cmd(C_LADDR, 8'h04);
        tick(6);
        set_cmd(C_WRPSG, 8'h77);
        tick(8);
        set_cmd(C_INACT, 8'h77);
        tick(4);
        check_cnt++; if (cur_addr !== 4'h4) $display("FAIL b2b_addr got=%h exp=4", cur_addr); else pass_cnt++;
        check_cnt++; if (regs_flat !== model_flat()) $display("FAIL b2b_write got=%h exp=%h", regs_flat, model_flat()); else pass_cnt++;
    endtask

    task automatic test_reset_mid_hold;
        cmd_then_inact(C_LADDR, 8'h03, 6);
        set_cmd(C_WRPSG, 8'h5A);
        tick(6);
        model[3] = 8'h5A;
        check_cnt++; if (regs_flat !== model_flat()) $display("FAIL hold_write got=%h exp=%h", regs_flat, model_flat()); else pass_cnt++;
        da_in = 8'hC3;
        tick(14);
        check_cnt++; if (regs_flat !== model_flat()) $display("FAIL hold_once got=%h exp=%h", regs_flat, model_flat()); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        check_cnt++; if (regs_flat !== 128'h0) $display("FAIL arst_regs got=%h exp=0", regs_flat); else pass_cnt++;
        check_cnt++; if (selected !== 1'b0) $display("FAIL arst_sel got=%b exp=0", selected); else pass_cnt++;
        check_cnt++; if (cur_addr !== 4'h0) $display("FAIL arst_addr got=%h exp=0", cur_addr); else pass_cnt++;
        check_cnt++; if (da_oe !== 1'b0) $display("FAIL arst_oe got=%b exp=0", da_oe); else pass_cnt++;
        check_cnt++; if (env_restart !== 1'b0) $display("FAIL arst_env got=%b exp=0", env_restart); else pass_cnt++;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        @(negedge clk);
        set_cmd(C_INACT, 8'h00);
        rst_n = 1'b1;
        tick(3);
        set_cmd(C_LADDR, 8'h09);
        tick(3);
        check_cnt++; if (cur_addr !== 4'h0) $display("FAIL post_rst_early got=%h exp=0", cur_addr); else pass_cnt++;
        tick(1);
        check_cnt++; if (cur_addr !== 4'h9) $display("FAIL post_rst_addr got=%h exp=9", cur_addr); else pass_cnt++;
        check_cnt++; if (selected !== 1'b1) $display("FAIL post_rst_sel got=%b exp=1", selected); else pass_cnt++;
        set_cmd(C_INACT, 8'h09);
        tick(4);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        rst_n = 1'b0;
        set_cmd(C_INACT, 8'h00);
        tick(3);
        test_reset();
        rst_n = 1'b1;
        tick(3);
        test_write_latency();
        test_read_masked();
        test_env_restart();
        test_chip_mismatch();
        test_glitch();
        test_back_to_back();
        test_reset_mid_hold();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
